// File: rtl/mul_seq_wb_if.sv
// rtl/mul_seq_wb_if.sv - operand/request and register-file write-back bundle for mul_seq_wb
interface mul_seq_wb_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [4:0]       DestReg;
  logic             Wide;
  logic             Busy;
  logic             Done;
  logic             RegWrite;
  logic [4:0]       WriteRegNo;
  logic [WIDTH-1:0] WriteData;
  logic [WIDTH-1:0] ProductHi;

  modport master (
    output Start, OpA, OpB, DestReg, Wide,
    input  Busy, Done, RegWrite, WriteRegNo, WriteData, ProductHi
  );

  modport slave (
    input  Start, OpA, OpB, DestReg, Wide,
    output Busy, Done, RegWrite, WriteRegNo, WriteData, ProductHi
  );
endinterface

// File: rtl/mul_seq_wb.sv
// rtl/mul_seq_wb.sv - sequential shift-add unsigned multiplier with register-file write-back
// One multiplier bit per cycle; low word then optional high word written back.
module mul_seq_wb #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  mul_seq_wb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, WR_LO, WR_HI} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [4:0]         dest_q, dest_d;
  logic               wide_q, wide_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               regwrite_q, regwrite_d;
  logic [4:0]         wrno_q, wrno_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   prodhi_q, prodhi_d;

  logic [WIDTH:0]     sum;
  logic               hi_go;

  // Register 31 has no successor, so the high word never wraps to register 0.
  assign hi_go = wide_q && (dest_q != 5'd31);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      dest_q     <= '0;
      wide_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
      wrno_q     <= '0;
      wdata_q    <= '0;
      prodhi_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      dest_q     <= dest_d;
      wide_q     <= wide_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      regwrite_q <= regwrite_d;
      wrno_q     <= wrno_d;
      wdata_q    <= wdata_d;
      prodhi_q   <= prodhi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dest_d   = dest_q;
    wide_d   = wide_q;
    sum      = '0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          mcand_d  = bus.OpA;
          mplier_d = bus.OpB;
          dest_d   = bus.DestReg;
          wide_d   = bus.Wide;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = MUL;
        end
      end
      MUL: begin
        // Carry lands in sum[WIDTH] and is shifted into the accumulator MSB.
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = WR_LO;
        end
      end
      WR_LO:   state_d = hi_go ? WR_HI : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every flop is valid for the whole cycle.
  always_comb begin
    busy_d     = (state_d != IDLE);
    done_d     = 1'b0;
    regwrite_d = 1'b0;
    wrno_d     = '0;
    wdata_d    = '0;
    prodhi_d   = prodhi_q;
    case (state_d)
      WR_LO: begin
        regwrite_d = (dest_q != 5'd0);
        wrno_d     = dest_q;
        wdata_d    = acc_d[WIDTH-1:0];
        if (!hi_go) begin
          done_d   = 1'b1;
          prodhi_d = acc_d[2*WIDTH-1:WIDTH];
        end
      end
      WR_HI: begin
        regwrite_d = 1'b1;
        wrno_d     = dest_q + 5'd1;
        wdata_d    = acc_d[2*WIDTH-1:WIDTH];
        done_d     = 1'b1;
        prodhi_d   = acc_d[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.RegWrite   = regwrite_q;
  assign bus.WriteRegNo = wrno_q;
  assign bus.WriteData  = wdata_q;
  assign bus.ProductHi  = prodhi_q;

endmodule

// File: tb/tb_mul_seq_wb.sv
// tb/tb_mul_seq_wb.sv - randomized self-checking bench for mul_seq_wb against a 64-bit product model
module tb_mul_seq_wb;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 Clock = ~Clock;

  mul_seq_wb_if #(.WIDTH(32)) bus();

  mul_seq_wb #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.Busy, bus.Done, bus.RegWrite, bus.WriteRegNo, bus.WriteData, bus.ProductHi}, 64'd0);
  endtask

  // Caller must be at a negedge; Start is raised in this cycle (cycle 0).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                        input logic w, input int restart_at);
    logic [63:0] p;
    logic [37:0] exp_wb;
    bit          hiw;
    int          last;
    p    = {32'd0, a} * {32'd0, b};
    hiw  = w && (d != 5'd31);
    last = hiw ? 34 : 33;
    bus.OpA     = a;
    bus.OpB     = b;
    bus.DestReg = d;
    bus.Wide    = w;
    bus.Start   = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge Clock);
      exp_wb = '0;
      if (k == 33) exp_wb = {d != 5'd0, d, p[31:0]};
      if (k == 34) exp_wb = {1'b1, d + 5'd1, p[63:32]};
      check("wb", {bus.RegWrite, bus.WriteRegNo, bus.WriteData}, exp_wb);
      check("busy", bus.Busy, 1);
      check("done", bus.Done, k == last);
      bus.Start   = (k == restart_at);
      bus.OpA     = (k == restart_at) ? 32'd1 : $urandom;
      bus.OpB     = (k == restart_at) ? 32'd1 : $urandom;
      bus.DestReg = 5'($urandom);
      bus.Wide    = 1'($urandom);
    end
    bus.Start = 1'b0;
    @(negedge Clock);
    check("idle_busy", bus.Busy, 0);
    check("idle_done", bus.Done, 0);
    check("idle_wb", {bus.RegWrite, bus.WriteRegNo, bus.WriteData}, 0);
    check("prodhi", bus.ProductHi, p[63:32]);
  endtask

  initial begin
    bus.Start   = 1'b0;
    bus.OpA     = '0;
    bus.OpB     = '0;
    bus.DestReg = '0;
    bus.Wide    = 1'b0;
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b1;
    @(negedge Clock);
    check_all_zero("post_reset_idle");

    run_op(32'd3, 32'd5, 5'd4, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1, 0);
    run_op(32'h8000_0000, 32'd4, 5'd31, 1'b1, 0);
    run_op(32'd7, 32'd9, 5'd0, 1'b0, 0);
    run_op(32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 1'b1, 0);
    run_op(32'd3, 32'd5, 5'd4, 1'b0, 10);
    run_op(32'd1, 32'd1, 5'd9, 1'b0, 0);
    run_op(32'd0, 32'hFFFF_FFFF, 5'd12, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      run_op($urandom, $urandom, 5'($urandom), 1'($urandom), (i % 3 == 0) ? 5 + i : 0);
    end

    // Abort in the middle of an operation.
    bus.OpA     = 32'd3;
    bus.OpB     = 32'd5;
    bus.DestReg = 5'd4;
    bus.Wide    = 1'b1;
    bus.Start   = 1'b1;
    @(negedge Clock);
    bus.Start = 1'b0;
    repeat (19) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check_all_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("abort_hold", {bus.Busy, bus.RegWrite}, 0);
    end
    Reset = 1'b1;
    @(negedge Clock);
    check_all_zero("abort_release");
    run_op(32'd6, 32'd7, 5'd2, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_wb.md
Name: mul_seq_wb

Overview:
- Sequential 32x32 unsigned shift-add multiplier in the execute stage, directly downstream of the 32x32-bit register file.
- Consumes the two register-file read ports (ReadData1/ReadData2) as operands.
- Returns the product to the register file through its write port (RegWrite, WriteRegNo, WriteData).
- Writes the low word to the destination register and, optionally, the high word to the destination register + 1.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- OpA  input  WIDTH  multiplicand, from register-file ReadData1.
- OpB  input  WIDTH  multiplier, from register-file ReadData2.
- DestReg  input  5  destination register number.
- Wide  input  1  1 = also write the high product word to DestReg+1.
- Busy  output  1  high from the cycle after an accepted Start until the return to IDLE.
- Done  output  1  one-cycle pulse in the final write-back cycle.
- RegWrite  output  1  register-file write enable.
- WriteRegNo  output  5  register-file write address.
- WriteData  output  WIDTH  register-file write data.
- ProductHi  output  WIDTH  high word of the last completed product; held until the next completion.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - Busy, Done, RegWrite, WriteRegNo, WriteData, ProductHi, counter and internal accumulator all go to 0.
  - Reset during MUL/WR_LO/WR_HI aborts the operation; no register-file write occurs after Reset asserts.
- States: IDLE, MUL, WR_LO, WR_HI.
- IDLE:
  - Start=1 latches OpA, OpB, DestReg and Wide.
  - Clears the 2*WIDTH accumulator, loads the counter with WIDTH, goes to MUL.
  - Busy=1 from the next cycle.
- MUL, one iteration per cycle, exactly WIDTH cycles:
  - If multiplier LSB=1, add the multiplicand into the upper half of the accumulator, with carry kept in a WIDTH+1-bit sum.
  - Shift accumulator and carry right by 1; shift multiplier right by 1; decrement counter.
  - At counter=1 go to WR_LO.
  - No overflow is possible: the full 2*WIDTH product is retained.
- WR_LO, one cycle:
  - WriteRegNo=DestReg, WriteData=product[WIDTH-1:0], RegWrite=1, except RegWrite=0 when DestReg=0 (register 0 is never written).
  - If Wide=1 and DestReg!=31, go to WR_HI.
  - Otherwise assert Done, load ProductHi, go to IDLE.
- WR_HI, one cycle:
  - WriteRegNo=DestReg+1, WriteData=product[2*WIDTH-1:WIDTH], RegWrite=1.
  - Assert Done, load ProductHi, go to IDLE.
- Wide=1 with DestReg=31: the high write is skipped (no wrap to register 0); the high word is available only on ProductHi.
- Wide=1 with DestReg=0: the low write is suppressed; the high word is still written to register 1.
- All outputs are registered. RegWrite, WriteRegNo and WriteData are stable for the entire write cycle, because the register file gates its write with the clock level.
- Outside write cycles: RegWrite=0, and WriteRegNo/WriteData return to 0.
- Start while Busy=1 is ignored; no queueing.
- Start is accepted again in the first IDLE cycle after Done.
- Latency, Start accepted at edge 0:
  - MUL occupies cycles 1..WIDTH.
  - WR_LO is cycle WIDTH+1 (33).
  - WR_HI is cycle WIDTH+2 (34).
  - Issue interval is 34 cycles without Wide, 35 with Wide.
- Operands changing after acceptance have no effect.

Test Plan:
- Reset released, OpA=3, OpB=5, DestReg=4, Wide=0, Start pulse -> Busy high for cycles 1..33; cycle 33: RegWrite=1, WriteRegNo=4, WriteData=0x0000000F, Done=1; ProductHi=0 afterwards.
- OpA=OpB=0xFFFFFFFF, DestReg=6, Wide=1 -> cycle 33: write reg 6 = 0x00000001; cycle 34: write reg 7 = 0xFFFFFFFE, Done=1; ProductHi=0xFFFFFFFE.
- OpA=0x80000000, OpB=4, DestReg=31, Wide=1 -> single write reg 31 = 0x00000000, Done in cycle 33, no WR_HI cycle, ProductHi=0x00000002.
- DestReg=0, Wide=0, OpA=7, OpB=9 -> RegWrite stays 0 for the whole operation; Done pulses in cycle 33.
- Second Start (OpA=1, OpB=1) at cycle 10 of an active 3x5 operation -> ignored; result 15 written in cycle 33. A Start issued in the cycle after Done yields product 1 at +33.
- Reset asserted at cycle 20 of an operation -> all outputs 0 immediately, Busy=0, no RegWrite pulse. After release, a fresh 6x7 to reg 2 writes 0x0000002A.
